// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU definitions for the pipeline control unit: bus widths, CR
// addresses, control-op and exception encodings, execution modes, and the
// packed layouts of the STATUS and CAUSE registers.
package pipe_ctrl_pkg;

  localparam int unsigned WORD_DATA_W = 32;
  localparam int unsigned WORD_ADDR_W = 30;
  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned CTRL_OP_W   = 2;
  localparam int unsigned ISA_EXP_W   = 3;

  typedef logic [WORD_DATA_W-1:0] word_data_t;
  typedef logic [WORD_ADDR_W-1:0] word_addr_t;
  typedef logic [REG_ADDR_W-1:0]  reg_addr_t;

  // Control-register addresses
  localparam reg_addr_t CREG_ADDR_STATUS     = 5'd0;
  localparam reg_addr_t CREG_ADDR_PRE_STATUS = 5'd1;
  localparam reg_addr_t CREG_ADDR_EPC        = 5'd2;
  localparam reg_addr_t CREG_ADDR_EXP_VECTOR = 5'd3;
  localparam reg_addr_t CREG_ADDR_CAUSE      = 5'd4;
  localparam reg_addr_t CREG_ADDR_INT_MASK   = 5'd5;
  localparam reg_addr_t CREG_ADDR_IRQ        = 5'd6;

  // Committed control operation from the MEM stage
  typedef enum logic [CTRL_OP_W-1:0] {
    CTRL_OP_NOP  = 2'd0,
    CTRL_OP_WRCR = 2'd1,
    CTRL_OP_EXRT = 2'd2
  } ctrl_op_e;

  // Exception codes
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_NO_EXP     = 3'd0;
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_EXT_INT    = 3'd1;
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_UNDEF_INSN = 3'd2;
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_OVERFLOW   = 3'd3;
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_MISS_ALIGN = 3'd4;
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_TRAP       = 3'd5;
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_PRV_VIO    = 3'd6;

  // Execution modes
  localparam logic CPU_KERNEL_MODE = 1'b0;
  localparam logic CPU_USER_MODE   = 1'b1;

  // STATUS / PRE_STATUS layout: {int_en, exe_mode}
  typedef struct packed {
    logic int_en;
    logic exe_mode;
  } status_t;

  // CAUSE layout: {dly_flag, exp_code}
  typedef struct packed {
    logic                 dly_flag;
    logic [ISA_EXP_W-1:0] exp_code;
  } cause_t;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline control unit and control-register file for the 5-stage CPU.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   creg_rd_addr/_data    CR read port serving the ID decoder (with WRCR bypass)
//   exe_mode              current mode (0 = kernel, 1 = user)
//   irq / int_detect      level interrupts in, registered unmasked-pending flag out
//   if_busy, mem_busy     bus waits; ld_hazard load-use hazard from ID
//   mem_*                 committed instruction info from the MEM stage
//   *_stall, *_flush      per-stage stall/flush controls
//   new_pc                redirect target, valid while if_flush = 1
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned IRQ_W       = 8,
  parameter logic [29:0] EXP_VEC_RST = 30'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_ADDR_W-1:0]  creg_rd_addr,
  output logic [WORD_DATA_W-1:0] creg_rd_data,
  output logic                   exe_mode,
  input  logic [IRQ_W-1:0]       irq,
  output logic                   int_detect,
  input  logic                   if_busy,
  input  logic                   mem_busy,
  input  logic                   ld_hazard,
  input  logic                   mem_en,
  input  logic [WORD_ADDR_W-1:0] mem_pc,
  input  logic                   mem_br_flag,
  input  logic [CTRL_OP_W-1:0]   mem_ctrl_op,
  input  logic [REG_ADDR_W-1:0]  mem_dst_addr,
  input  logic [ISA_EXP_W-1:0]   mem_exp_code,
  input  logic [WORD_DATA_W-1:0] mem_out,
  output logic                   if_stall,
  output logic                   id_stall,
  output logic                   ex_stall,
  output logic                   mem_stall,
  output logic                   if_flush,
  output logic                   id_flush,
  output logic                   ex_flush,
  output logic                   mem_flush,
  output logic [WORD_ADDR_W-1:0] new_pc
);

  status_t          status_q;
  status_t          pre_status_q;
  word_addr_t       epc_q;
  word_addr_t       exp_vector_q;
  cause_t           cause_q;
  logic [IRQ_W-1:0] int_mask_q;

  ctrl_op_e   ctrl_op;
  logic       commit;
  logic       exp_take;
  logic       exrt_take;
  logic       wrcr_take;
  logic       wr_writable;
  word_data_t wr_field;

  assign exe_mode = status_q.exe_mode;

  // Commit qualification; exception outranks EXRT, which outranks WRCR
  assign ctrl_op   = ctrl_op_e'(mem_ctrl_op);
  assign commit    = mem_en & ~mem_busy;
  assign exp_take  = commit & (mem_exp_code != ISA_EXP_NO_EXP);
  assign exrt_take = commit & ~exp_take & (ctrl_op == CTRL_OP_EXRT);
  assign wrcr_take = commit & ~exp_take & (ctrl_op == CTRL_OP_WRCR);

  // Writable field of the WRCR target, shared by the write path and the read bypass
  always_comb begin
    wr_field    = '0;
    wr_writable = 1'b0;
    case (mem_dst_addr)
      CREG_ADDR_STATUS, CREG_ADDR_PRE_STATUS: begin
        wr_field    = {30'b0, mem_out[1:0]};
        wr_writable = 1'b1;
      end
      CREG_ADDR_EPC, CREG_ADDR_EXP_VECTOR: begin
        wr_field    = {mem_out[31:2], 2'b00};
        wr_writable = 1'b1;
      end
      CREG_ADDR_INT_MASK: begin
        wr_field    = WORD_DATA_W'(mem_out[IRQ_W-1:0]);
        wr_writable = 1'b1;
      end
      default: begin
        wr_field    = '0;
        wr_writable = 1'b0;
      end
    endcase
  end

  // CR read port with same-cycle WRCR bypass
  always_comb begin
    creg_rd_data = '0;
    case (creg_rd_addr)
      CREG_ADDR_STATUS:     creg_rd_data = {30'b0, status_q};
      CREG_ADDR_PRE_STATUS: creg_rd_data = {30'b0, pre_status_q};
      CREG_ADDR_EPC:        creg_rd_data = {epc_q, 2'b00};
      CREG_ADDR_EXP_VECTOR: creg_rd_data = {exp_vector_q, 2'b00};
      CREG_ADDR_CAUSE:      creg_rd_data = {28'b0, cause_q};
      CREG_ADDR_INT_MASK:   creg_rd_data = WORD_DATA_W'(int_mask_q);
      CREG_ADDR_IRQ:        creg_rd_data = WORD_DATA_W'(irq);
      default:              creg_rd_data = '0;
    endcase
    if (wrcr_take && wr_writable && (mem_dst_addr == creg_rd_addr)) begin
      creg_rd_data = wr_field;
    end
  end

  // Stalls, flushes and redirect target
  always_comb begin
    if_stall  = if_busy | ld_hazard | mem_busy;
    id_stall  = if_busy | mem_busy;
    ex_stall  = mem_busy;
    mem_stall = mem_busy;
    if_flush  = 1'b0;
    id_flush  = ld_hazard;
    ex_flush  = 1'b0;
    mem_flush = 1'b0;
    new_pc    = '0;
    if (exp_take) begin
      {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
      new_pc = exp_vector_q;
    end else if (exrt_take) begin
      {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
      new_pc = epc_q;
    end
  end

  // CR file state and interrupt detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_q     <= '{int_en: 1'b0, exe_mode: CPU_KERNEL_MODE};
      pre_status_q <= '{int_en: 1'b0, exe_mode: CPU_KERNEL_MODE};
      epc_q        <= '0;
      exp_vector_q <= EXP_VEC_RST;
      cause_q      <= '{dly_flag: 1'b0, exp_code: ISA_EXP_NO_EXP};
      int_mask_q   <= '1;
      int_detect   <= 1'b0;
    end else if (exp_take) begin
      pre_status_q <= status_q;
      status_q     <= '{int_en: 1'b0, exe_mode: CPU_KERNEL_MODE};
      cause_q      <= '{dly_flag: mem_br_flag, exp_code: mem_exp_code};
      // A delay-slot fault restarts at the branch one word earlier
      epc_q        <= mem_br_flag ? (mem_pc - 30'd1) : mem_pc;
      int_detect   <= 1'b0;
    end else begin
      int_detect <= status_q.int_en & (|(irq & ~int_mask_q));
      if (exrt_take) begin
        status_q <= pre_status_q;
      end
      if (wrcr_take) begin
        case (mem_dst_addr)
          CREG_ADDR_STATUS:     status_q     <= status_t'(mem_out[1:0]);
          CREG_ADDR_PRE_STATUS: pre_status_q <= status_t'(mem_out[1:0]);
          CREG_ADDR_EPC:        epc_q        <= mem_out[31:2];
          CREG_ADDR_EXP_VECTOR: exp_vector_q <= mem_out[31:2];
          CREG_ADDR_INT_MASK:   int_mask_q   <= mem_out[IRQ_W-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule
